// File: rtl/char_lcd_ctrl_if.sv
// Host-side port of the character LCD controller: buffer write port, refresh and
// blanking controls, plus the ready/busy status returned to the dashboard logic.
interface char_lcd_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_char;
    logic       refresh_req;
    logic       blank;
    logic       ready;
    logic       busy;

    modport master (
        output wr_en, wr_row, wr_col, wr_char, refresh_req, blank,
        input  ready, busy
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_char, refresh_req, blank,
        output ready, busy
    );
endinterface

// File: rtl/char_lcd_ctrl.sv
// HD44780-compatible 8-bit character LCD controller: power-up init, shadow character
// buffer with per-row dirty tracking, and display on/off control.
module char_lcd_ctrl #(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int CYC_POWERUP = 2_000_000,
    parameter int CYC_CMD     = 20_000,
    parameter int CYC_CLR     = 100_000,
    parameter int E_SETUP     = 5_000,
    parameter int E_HIGH      = 10_000
) (
    input  logic           clk,
    input  logic           rst,
    char_lcd_ctrl_if.slave host,
    output logic           lcd_rs,
    output logic           lcd_rw,
    output logic           lcd_e,
    output logic [7:0]     lcd_data
);
    localparam int NCHR = ROWS * COLS;
    localparam int AW   = $clog2(NCHR);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        DISP_CTRL,
        ROW_CMD,
        ROW_WR
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      buf_mem [NCHR];
    logic [ROWS-1:0] dirty, dirty_clr, dirty_set;
    logic            blank_reg, blank_nx;
    logic [31:0]     pwr_cnt, k_cnt, k_nx;
    logic            cur_clr;
    logic [3:0]      init_idx, idx_nx;
    logic [1:0]      cur_row, row_nx, low_row;
    logic [4:0]      cur_col, col_nx;
    logic            busy_r, ready_r;

    logic            start, start_rs, start_clr, stop, go_ready;
    logic [7:0]      start_byte;
    logic            byte_done, any_dirty, wr_ok;
    logic [AW-1:0]   wr_addr, rd_addr;

    function automatic logic [7:0] init_byte(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd2: return 8'h30;
            4'd3:             return 8'h38;
            4'd4:             return 8'h08;
            4'd5:             return 8'h01;
            4'd6:             return 8'h06;
            default:          return 8'h0C;
        endcase
    endfunction

    function automatic logic [7:0] row_addr(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'(COLS);
            default: return 8'(8'h40 + COLS);
        endcase
    endfunction

    assign lcd_rw     = 1'b0;
    assign host.ready = ready_r;
    assign host.busy  = busy_r;

    assign k_nx      = k_cnt + 32'd1;
    assign byte_done = busy_r && (k_cnt == (cur_clr ? 32'(CYC_CLR - 1) : 32'(CYC_CMD - 1)));
    assign wr_ok     = host.wr_en && (int'(host.wr_row) < ROWS) && (int'(host.wr_col) < COLS);
    assign wr_addr   = AW'(int'(host.wr_row) * COLS + int'(host.wr_col));
    assign rd_addr   = AW'(int'(cur_row) * COLS + int'(cur_col));
    assign any_dirty = |dirty;
    // A write in the same cycle as a row's dirty clear must win, so set is ORed in last
    assign dirty_set = (wr_ok ? (ROWS'(1) << host.wr_row) : '0) | {ROWS{host.refresh_req}};

    always_comb begin
        low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (dirty[r]) low_row = 2'(r);
        end
    end

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        start_byte = 8'h00;
        start_rs   = 1'b0;
        start_clr  = 1'b0;
        stop       = 1'b0;
        go_ready   = 1'b0;
        dirty_clr  = '0;
        row_nx     = cur_row;
        col_nx     = cur_col;
        idx_nx     = init_idx;
        blank_nx   = blank_reg;
        case (state)
            PWR_WAIT: begin
                if (pwr_cnt == 32'(CYC_POWERUP)) begin
                    start      = 1'b1;
                    start_byte = init_byte(4'd0);
                    idx_nx     = 4'd1;
                    state_nx   = INIT;
                end
            end
            INIT: begin
                if (byte_done) begin
                    if (init_idx == 4'd8) begin
                        stop     = 1'b1;
                        go_ready = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        start      = 1'b1;
                        start_byte = init_byte(init_idx);
                        start_clr  = (init_idx == 4'd5);
                        idx_nx     = init_idx + 4'd1;
                    end
                end
            end
            IDLE: begin
                // Blanking changes take precedence over pending row rewrites
                if (host.blank != blank_reg) begin
                    start      = 1'b1;
                    start_byte = host.blank ? 8'h08 : 8'h0C;
                    blank_nx   = host.blank;
                    state_nx   = DISP_CTRL;
                end else if (any_dirty) begin
                    start      = 1'b1;
                    start_byte = 8'h80 | row_addr(low_row);
                    row_nx     = low_row;
                    col_nx     = '0;
                    dirty_clr  = ROWS'(1) << low_row;
                    state_nx   = ROW_CMD;
                end
            end
            DISP_CTRL: begin
                if (byte_done) begin
                    stop     = 1'b1;
                    state_nx = IDLE;
                end
            end
            ROW_CMD, ROW_WR: begin
                if (byte_done) begin
                    if (state == ROW_WR && cur_col == 5'(COLS)) begin
                        stop     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        start      = 1'b1;
                        start_rs   = 1'b1;
                        start_byte = buf_mem[rd_addr];
                        col_nx     = cur_col + 5'd1;
                        state_nx   = ROW_WR;
                    end
                end
            end
            default: state_nx = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            pwr_cnt   <= '0;
            k_cnt     <= '0;
            cur_clr   <= 1'b0;
            init_idx  <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            busy_r    <= 1'b0;
            ready_r   <= 1'b0;
            blank_reg <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            state     <= state_nx;
            init_idx  <= idx_nx;
            cur_row   <= row_nx;
            cur_col   <= col_nx;
            blank_reg <= blank_nx;
            if (state == PWR_WAIT) pwr_cnt <= pwr_cnt + 32'd1;
            if (go_ready) ready_r <= 1'b1;
            // E strobe is registered from the next k so it rises exactly at k = E_SETUP
            if (start) begin
                busy_r   <= 1'b1;
                k_cnt    <= '0;
                cur_clr  <= start_clr;
                lcd_rs   <= start_rs;
                lcd_data <= start_byte;
                lcd_e    <= (E_SETUP == 0);
            end else if (stop) begin
                busy_r <= 1'b0;
                k_cnt  <= '0;
                lcd_e  <= 1'b0;
            end else if (busy_r) begin
                k_cnt <= k_nx;
                lcd_e <= (k_nx >= 32'(E_SETUP)) && (k_nx < 32'(E_SETUP + E_HIGH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty <= '1;
            for (int i = 0; i < NCHR; i++) buf_mem[i] <= 8'h20;
        end else begin
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            if (wr_ok) buf_mem[wr_addr] <= host.wr_char;
        end
    end
endmodule

// File: tb/tb_char_lcd_ctrl.sv
// Scoreboard bench for char_lcd_ctrl: a character-grid model predicts every LCD bus
// transaction, and an independent bus monitor checks bytes, start cycles and E timing.
module tb_char_lcd_ctrl;
    localparam int COLS        = 16;
    localparam int ROWS        = 2;
    localparam int CYC_POWERUP = 100;
    localparam int CYC_CMD     = 20;
    localparam int CYC_CLR     = 40;
    localparam int E_SETUP     = 2;
    localparam int E_HIGH      = 6;
    localparam int READY_CYC   = CYC_POWERUP + 7 * CYC_CMD + CYC_CLR;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         start;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    char_lcd_ctrl_if host ();

    char_lcd_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .CYC_POWERUP(CYC_POWERUP), .CYC_CMD(CYC_CMD),
        .CYC_CLR(CYC_CLR), .E_SETUP(E_SETUP), .E_HIGH(E_HIGH)
    ) dut (
        .clk(clk), .rst(rst), .host(host),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = -1;
    int         txn_seen = 0;
    bit         mon_active = 1'b0;
    txn_t       exp_q[$];
    logic [7:0] mbuf [ROWS][COLS];
    logic       mblank = 1'b0;

    always @(posedge clk) begin
        if (rst) cyc = -1;
        else     cyc = cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void pushByte(input logic rs, input logic [7:0] data, input int start);
        txn_t t;
        t.rs = rs; t.data = data; t.start = start;
        exp_q.push_back(t);
    endfunction

    function automatic void pushRow(input int r);
        pushByte(1'b0, 8'h80 | ((r == 1) ? 8'h40 : 8'h00), -1);
        for (int c = 0; c < COLS; c++) pushByte(1'b1, mbuf[r][c], -1);
    endfunction

    // Init bytes go back to back; the clear byte occupies the longer CYC_CLR slot
    function automatic void pushInit();
        logic [7:0] seq [8];
        int         t;
        seq = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        t = CYC_POWERUP;
        for (int i = 0; i < 8; i++) begin
            pushByte(1'b0, seq[i], t);
            t += (seq[i] == 8'h01) ? CYC_CLR : CYC_CMD;
        end
    endfunction

    function automatic void resetModel();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mbuf[r][c] = 8'h20;
        mblank = 1'b0;
    endfunction

    task automatic driveInputs(input logic we, input logic [1:0] row, input logic [4:0] col,
                               input logic [7:0] ch, input logic refr, input logic blk);
        @(posedge clk); #1;
        host.wr_en = we; host.wr_row = row; host.wr_col = col; host.wr_char = ch;
        host.refresh_req = refr; host.blank = blk;
        @(posedge clk); #1;
        host.wr_en = 1'b0; host.refresh_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input int row, input int col, input logic [7:0] ch,
                                 input logic refr, input logic blk);
        bit d [ROWS];
        for (int r = 0; r < ROWS; r++) d[r] = refr;
        if (we && row < ROWS && col < COLS) begin
            mbuf[row][col] = ch;
            d[row] = 1'b1;
        end
        if (blk != mblank) begin
            pushByte(1'b0, blk ? 8'h08 : 8'h0C, -1);
            mblank = blk;
        end
        for (int r = 0; r < ROWS; r++) if (d[r]) pushRow(r);
        driveInputs(we, 2'(row), 5'(col), ch, refr, blk);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || host.busy || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        checkOutput("drain", {31'd0, (exp_q.size() == 0 && !host.busy)}, 32'd1);
    endtask

    task automatic checkReady();
        int n = 0;
        while (cyc < READY_CYC - 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before", 32'(host.ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_at", 32'(host.ready), 32'd1);
    endtask

    task automatic waitTxns(input string name, input int target);
        int n = 0;
        while (txn_seen < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(txn_seen >= target), 32'd1);
    endtask

    // Bus monitor: detects each transaction start, pops the scoreboard and checks timing
    initial begin : monitor
        int         k, len;
        logic [7:0] d;
        logic       r;
        bit         e_ok, hold_ok;
        txn_t       t;
        k = 0; len = 0; d = 8'h00; r = 1'b0; e_ok = 1'b1; hold_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
                continue;
            end
            if (mon_active) begin
                k++;
                if (k == len) begin
                    checkOutput("e_timing", 32'(e_ok), 32'd1);
                    checkOutput("bus_hold", 32'(hold_ok), 32'd1);
                    mon_active = 1'b0;
                end
            end
            if (!mon_active && host.busy) begin
                mon_active = 1'b1;
                k = 0; d = lcd_data; r = lcd_rs; e_ok = 1'b1; hold_ok = 1'b1;
                len = (!r && d == 8'h01) ? CYC_CLR : CYC_CMD;
                txn_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_txn: got rs=%0d data=0x%02h, expected no transaction (cycle %0d)",
                             r, d, cyc);
                end else begin
                    t = exp_q.pop_front();
                    checkOutput("lcd_byte", {23'd0, r, d}, {23'd0, t.rs, t.data});
                    if (t.start >= 0) checkOutput("start_cycle", 32'(cyc), 32'(t.start));
                end
            end
            if (mon_active) begin
                if (lcd_e !== (k >= E_SETUP && k < E_SETUP + E_HIGH)) e_ok = 1'b0;
                if (lcd_data !== d || lcd_rs !== r || host.busy !== 1'b1 || lcd_rw !== 1'b0) hold_ok = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int base, extra;
        host.wr_en = 1'b0; host.wr_row = '0; host.wr_col = '0; host.wr_char = '0;
        host.refresh_req = 1'b0; host.blank = 1'b0;
        resetModel();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_lcd_e", 32'(lcd_e), 32'd0);
        checkOutput("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        checkOutput("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        checkOutput("rst_lcd_data", 32'(lcd_data), 32'd0);
        checkOutput("rst_busy", 32'(host.busy), 32'd0);
        checkOutput("rst_ready", 32'(host.ready), 32'd0);

        $display("[TB] reset release and init sequence");
        pushInit(); pushRow(0); pushRow(1);
        @(posedge clk); #1 rst = 1'b0;
        checkReady();
        waitDrain(3000);

        $display("[TB] idle write row1 col3");
        applyStimulus(1'b1, 1, 3, "A", 1'b0, mblank);
        waitDrain(2000);

        $display("[TB] blanking on/off");
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
        waitDrain(2000);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
        waitDrain(2000);

        $display("[TB] out-of-range writes");
        applyStimulus(1'b1, 2, 0, "Q", 1'b0, mblank);
        waitDrain(2000);
        applyStimulus(1'b1, 0, 16, "Q", 1'b0, mblank);
        waitDrain(2000);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, mblank);
        waitDrain(2000);

        // The late write lands mid-row: it shows up in this pass and forces one re-send
        $display("[TB] write during row transfer");
        base = txn_seen;
        mbuf[0][0] = "B";
        mbuf[0][15] = "Z";
        pushRow(0); pushRow(0);
        driveInputs(1'b1, 2'd0, 5'd0, "B", 1'b0, mblank);
        waitTxns("reach_row0_col5", base + 7);
        driveInputs(1'b1, 2'd0, 5'd15, "Z", 1'b0, mblank);
        waitDrain(2000);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 24; it++) begin
            logic       we, refr, blk;
            int         row, col;
            logic [7:0] ch;
            we   = ($urandom_range(0, 3) != 0);
            row  = $urandom_range(0, 3);
            col  = $urandom_range(0, 19);
            ch   = 8'($urandom_range(32, 126));
            refr = ($urandom_range(0, 4) == 0);
            blk  = ($urandom_range(0, 3) == 0) ? !mblank : mblank;
            applyStimulus(we, row, col, ch, refr, blk);
            waitDrain(2000);
        end

        $display("[TB] reset during row1 byte 7");
        extra = mblank ? 1 : 0;
        base = txn_seen;
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        waitTxns("reach_row1_col7", base + extra + (COLS + 1) + 1 + 8);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_lcd_e", 32'(lcd_e), 32'd0);
        checkOutput("rst_mid_busy", 32'(host.busy), 32'd0);
        checkOutput("rst_mid_ready", 32'(host.ready), 32'd0);
        resetModel();
        pushInit(); pushRow(0); pushRow(1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkReady();
        waitDrain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
